// File: rtl/sha256_block_engine_if.sv
// en/rdy request channel between the SHA-256 task controller (master) and the block engine (slave).
interface sha256_block_engine_if;
  logic         en;
  logic         first;
  logic [511:0] block;
  logic         rdy;
  logic         done;
  logic [255:0] digest;

  modport master (output en, first, block, input rdy, done, digest);
  modport slave  (input en, first, block, output rdy, done, digest);
endinterface

// File: rtl/sha256_block_engine.sv
// SHA-256 compression of one pre-padded 512-bit block per request, one round per cycle,
// with the running digest chained across blocks unless first is set.
module sha256_block_engine #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sha256_block_engine_if.slave bus
);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t       state;
  logic [5:0]   t;
  logic         first_q;
  logic         rdy_q;
  logic         done_q;
  logic [255:0] digest_q;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  w [16];
  logic [31:0]  t1, t2, w_new;
  logic [255:0] base, digest_next;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign bus.rdy    = rdy_q;
  assign bus.done   = done_q;
  assign bus.digest = digest_q;

  // w[0] always holds W[t]; w[15] is refilled with W[t+16] as the window slides.
  always_comb begin
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[0];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    base = first_q ? IV : digest_q;
    digest_next = {a + base[255:224], b + base[223:192], c + base[191:160], d + base[159:128],
                   e + base[127:96],  f + base[95:64],   g + base[63:32],   h + base[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
      digest_q <= '0;
      t        <= '0;
      first_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.en) begin
            for (int unsigned i = 0; i < 16; i++) w[i] <= bus.block[511 - 32*i -: 32];
            {a, b, c, d, e, f, g, h} <= bus.first ? IV : digest_q;
            first_q <= bus.first;
            t       <= '0;
            rdy_q   <= 1'b0;
            state   <= ROUND;
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          t <= t + 6'd1;
          if (t == LAST) state <= FINAL;
        end
        FINAL: begin
          digest_q <= digest_next;
          done_q   <= 1'b1;
          rdy_q    <= 1'b1;
          t        <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
